// File: rtl/lp_q_channel_buffer.sv
`default_nettype none
// ============================================================================
// Module      : lp_q_channel_buffer
// Description : DEPTH x DATA_W show-ahead FIFO at a power-domain boundary,
//               gated by a Q-channel controller. Before it accepts a quiesce
//               request, the controller asks upstream to flush and waits for
//               the FIFO to drain. It denies the request if the drain does not
//               finish within FLUSH_TIMEOUT cycles.
// Options     : define LPC_OCC_COUNT_EN to add the occupancy_o and
//               overflow_o observation ports.
// Revision    : 1.0 - initial release
// ============================================================================
module lp_q_channel_buffer #(
    parameter int DATA_W        = 8,
    parameter int DEPTH         = 6,
    parameter int FLUSH_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_wakeup_i,
    input  logic              wr_valid_i,
    output logic              wr_ready_o,
    input  logic [DATA_W-1:0] wr_payload_i,
    output logic              wr_flush_o,
    input  logic              wr_done_i,
    output logic              rd_valid_o,
    input  logic              rd_ready_i,
    output logic [DATA_W-1:0] rd_payload_o,
    input  logic              qreqn_i,
    output logic              qacceptn_o,
    output logic              qdeny_o,
    output logic              qactive_o
`ifdef LPC_OCC_COUNT_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] occupancy_o,
    output logic                       overflow_o
`endif
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int OCC_W   = $clog2(DEPTH + 1);
    localparam int TIMER_W = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;

    localparam logic [2:0] Q_RUN     = 3'd0;
    localparam logic [2:0] Q_REQUEST = 3'd1;
    localparam logic [2:0] Q_STOPPED = 3'd2;
    localparam logic [2:0] Q_EXIT    = 3'd3;
    localparam logic [2:0] Q_DENIED  = 3'd4;

    logic [2:0]         state;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [OCC_W-1:0]   occ;
    logic [TIMER_W-1:0] timer;
    logic               qacceptn_q;
    logic               qdeny_q;
    logic               flush_q;
    logic               qactive_q;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic timeout_hit;
    logic push_open;
    logic pop_open;

    assign full  = (occ == OCC_W'(DEPTH));
    assign empty = (occ == '0);

    // Writes are open while the channel is running, negotiating, or denied.
    // Reads are also open in those states. They close only while the domain
    // is stopped or exiting.
    assign push_open = (state == Q_RUN) || (state == Q_REQUEST) || (state == Q_DENIED);
    assign pop_open  = (state != Q_STOPPED) && (state != Q_EXIT);

    assign wr_ready_o   = ~full & push_open;
    assign rd_valid_o   = ~empty & pop_open;
    assign rd_payload_o = mem[rd_ptr];
    assign push         = wr_valid_i & wr_ready_o;
    assign pop          = rd_ready_i & rd_valid_o;

    assign timeout_hit = (FLUSH_TIMEOUT != 0) && (timer == TIMER_W'(FLUSH_TIMEOUT - 1));

    assign qacceptn_o = qacceptn_q;
    assign qdeny_o    = qdeny_q;
    assign wr_flush_o = flush_q;
    assign qactive_o  = if_wakeup_i | qactive_q;

    // Storage is not reset. Entries are only observable once they are written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_payload_i;
        end
    end

    // Pointers and occupancy. A push and a pop in the same cycle leave the
    // occupancy unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                occ <= occ + 1'b1;
            end else if (pop && !push) begin
                occ <= occ - 1'b1;
            end
        end
    end

    // Q-channel handshake. Accept takes priority over timeout, and the flush
    // request drops whenever the request phase ends.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= Q_RUN;
            qacceptn_q <= 1'b1;
            qdeny_q    <= 1'b0;
            flush_q    <= 1'b0;
            timer      <= '0;
        end else begin
            case (state)
                Q_RUN: begin
                    if (!qreqn_i) begin
                        state   <= Q_REQUEST;
                        flush_q <= 1'b1;
                        timer   <= '0;
                    end
                end
                Q_REQUEST: begin
                    timer <= timer + 1'b1;
                    if (qreqn_i) begin
                        state   <= Q_RUN;
                        flush_q <= 1'b0;
                    end else if (wr_done_i && empty) begin
                        state      <= Q_STOPPED;
                        qacceptn_q <= 1'b0;
                        flush_q    <= 1'b0;
                    end else if (timeout_hit) begin
                        state   <= Q_DENIED;
                        qdeny_q <= 1'b1;
                        flush_q <= 1'b0;
                    end
                end
                Q_STOPPED: begin
                    if (qreqn_i) begin
                        state      <= Q_EXIT;
                        qacceptn_q <= 1'b1;
                    end
                end
                Q_EXIT: begin
                    state <= Q_RUN;
                end
                Q_DENIED: begin
                    if (qreqn_i) begin
                        state   <= Q_RUN;
                        qdeny_q <= 1'b0;
                    end
                end
                default: begin
                    state      <= Q_RUN;
                    qacceptn_q <= 1'b1;
                    qdeny_q    <= 1'b0;
                    flush_q    <= 1'b0;
                end
            endcase
        end
    end

    // Activity hint: buffered data or pending traffic at either side.
    always_ff @(posedge clk) begin
        if (reset) begin
            qactive_q <= 1'b0;
        end else begin
            qactive_q <= ~empty | wr_valid_i | rd_ready_i;
        end
    end

`ifdef LPC_OCC_COUNT_EN
    logic overflow_q;

    assign occupancy_o = occ;
    assign overflow_o  = overflow_q;

    // Flags a write attempt that arrived while the FIFO was full in normal run.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= wr_valid_i & full & (state == Q_RUN);
        end
    end
`endif

endmodule
`default_nettype wire
